// File: rtl/qspi_req_arbiter.sv
// QSPI request arbiter: picks between XIP fetch and command requesters,
// latches the winner's address/attributes, starts the flash FSM, holds the
// attributes until the FSM finishes, then acks the owner. Commands are
// protected from starvation, and a watchdog aborts hung transfers.
module qspi_req_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              fch_req,
  input  logic [ADDR_W-1:0] fch_addr,
  output logic              fch_ack,
  input  logic              cmd_req,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_type,
  output logic              cmd_ack,
  output logic              fsm_start,
  output logic [ADDR_W-1:0] fsm_addr,
  output logic              fsm_addr_valid,
  output logic              fsm_dummy_valid,
  output logic              fsm_rd_valid,
  output logic              fsm_wr_valid,
  output logic              fsm_erase_valid,
  input  logic              fsm_next_req,
  input  logic              fsm_state_free,
  output logic              grant_cmd,
  output logic              timeout_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Attribute vector ordering: {addr, dummy, rd, wr, erase}
  localparam logic [4:0] ATTR_FETCH = 5'b11100;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  // Value the watchdog holds during the (2^TIMEOUT_W-1)th BUSY cycle
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [4:0]          attr_q, attr_d;
  logic                gcmd_q, gcmd_d;
  logic                terr_q, terr_d;
  logic                cmd_wins;

  // Command wins when fetch is absent or fetch has had its quota of grants
  assign cmd_wins = cmd_req && (!fch_req || (starve_q == STARVE_LIM));

  // Next-state, latch and watchdog logic
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wdog_d   = wdog_q;
    addr_d   = addr_q;
    attr_d   = attr_q;
    gcmd_d   = gcmd_q;
    // A watchdog set below overrides the clear
    terr_d   = terr_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (fsm_state_free && (fch_req || cmd_req)) begin
          state_d = ST_LAUNCH;
          if (cmd_wins) begin
            addr_d   = cmd_addr;
            gcmd_d   = 1'b1;
            starve_d = 4'd0;
            case (cmd_type)
              2'b00:   attr_d = 5'b00100;
              2'b01:   attr_d = 5'b00010;
              2'b10:   attr_d = 5'b10010;
              default: attr_d = 5'b10001;
            endcase
          end else begin
            addr_d = fch_addr;
            gcmd_d = 1'b0;
            attr_d = ATTR_FETCH;
            if (!cmd_req)
              starve_d = 4'd0;
            else if (starve_q != STARVE_LIM)
              starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (fsm_next_req) begin
          state_d = ST_RELEASE;
          wdog_d  = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d = ST_RELEASE;
          wdog_d  = '0;
          terr_d  = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        attr_d  = 5'b00000;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-attribute registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
      wdog_q   <= '0;
      addr_q   <= '0;
      attr_q   <= 5'b00000;
      gcmd_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      attr_q   <= attr_d;
      gcmd_q   <= gcmd_d;
      terr_q   <= terr_d;
    end
  end

  assign fsm_start       = (state_q == ST_LAUNCH);
  assign fch_ack         = (state_q == ST_RELEASE) && !gcmd_q;
  assign cmd_ack         = (state_q == ST_RELEASE) && gcmd_q;
  assign fsm_addr        = addr_q;
  assign fsm_addr_valid  = attr_q[4];
  assign fsm_dummy_valid = attr_q[3];
  assign fsm_rd_valid    = attr_q[2];
  assign fsm_wr_valid    = attr_q[1];
  assign fsm_erase_valid = attr_q[0];
  assign grant_cmd       = gcmd_q;
  assign timeout_err     = terr_q;

endmodule
